// File: rtl/predistort_gather.sv
// predistort_gather
//   Packet-level N:1 round-robin merger for the per-channel predistortion
//   return path. Whole packets from NUM_CHANNELS AXI-stream inputs are
//   interleaved into one stream, each beat tagged with its source channel.
//
// Ports
//   clk, reset_n (async, active-low), clear (sync, active-high soft clear)
//   i_tdata/i_tlast/i_tvalid/i_tready : per-channel input streams, packed
//   o_tdata/o_tchan/o_tlast/o_tvalid/o_tready : merged output stream
//   pkt_cnt : per-channel completed packet counters (16 bit, wrapping)
//   busy    : high while passing a packet or while output data is buffered
module predistort_gather #(
    parameter int                        WIDTH        = 16,
    parameter int                        NUM_CHANNELS = 4,
    parameter int                        CHAN_W       = 3,
    parameter logic [NUM_CHANNELS-1:0]   ACTIVE_MASK  = 4'b1111
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic [NUM_CHANNELS*WIDTH-1:0] i_tdata,
    input  logic [NUM_CHANNELS-1:0]      i_tlast,
    input  logic [NUM_CHANNELS-1:0]      i_tvalid,
    output logic [NUM_CHANNELS-1:0]      i_tready,
    output logic [WIDTH-1:0]             o_tdata,
    output logic [CHAN_W-1:0]            o_tchan,
    output logic                         o_tlast,
    output logic                         o_tvalid,
    input  logic                         o_tready,
    output logic [NUM_CHANNELS*16-1:0]   pkt_cnt,
    output logic                         busy
);

    localparam int EW = CHAN_W + 1 + WIDTH;   // buffer entry: {chan, last, data}
    localparam int TW = CHAN_W + 1;           // room for ptr + offset before wrap

    typedef enum logic [0:0] {IDLE = 1'b0, PASS = 1'b1} state_e;

    state_e                      state_q, state_d;
    logic [CHAN_W-1:0]           sel_q, sel_d;
    logic [CHAN_W-1:0]           ptr_q, ptr_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [EW-1:0]               ent0_q, ent0_d;  // head entry, drives the outputs
    logic [EW-1:0]               ent1_q, ent1_d;
    logic                        vld_q, vld_d;
    logic                        busy_q, busy_d;
    logic [NUM_CHANNELS-1:0]     rdy_q, rdy_d;
    logic [NUM_CHANNELS*16-1:0]  pkt_cnt_q, pkt_cnt_d;

    logic [NUM_CHANNELS-1:0]     elig_s;
    logic                        found_s;
    logic [CHAN_W-1:0]           cand_s;
    logic [TW-1:0]               tgt_s;
    logic [WIDTH-1:0]            in_data_s;
    logic                        in_last_s;
    logic                        accept_s;
    logic                        pop_s;
    logic [EW-1:0]               new_ent_s;

    // Round-robin search: first eligible channel at or after ptr, with wrap.
    always_comb begin
        elig_s  = i_tvalid & ACTIVE_MASK;
        found_s = 1'b0;
        cand_s  = '0;
        tgt_s   = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            tgt_s = {1'b0, ptr_q} + TW'(k);
            if (tgt_s >= TW'(NUM_CHANNELS)) begin
                tgt_s = tgt_s - TW'(NUM_CHANNELS);
            end else begin
                tgt_s = tgt_s;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (!found_s && elig_s[c] && (tgt_s == TW'(c))) begin
                    found_s = 1'b1;
                    cand_s  = CHAN_W'(c);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Mux the granted channel's beat and detect handshakes on both sides.
    always_comb begin
        in_data_s = '0;
        in_last_s = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (CHAN_W'(c) == sel_q) begin
                in_data_s = i_tdata[c*WIDTH +: WIDTH];
                in_last_s = i_tlast[c];
            end else begin
                in_last_s = in_last_s;
            end
        end
        // rdy_q is only ever set for the granted channel, so any overlap is the accept.
        accept_s  = |(i_tvalid & rdy_q);
        pop_s     = vld_q & o_tready;
        new_ent_s = {sel_q, in_last_s, in_data_s};
    end

    // Next-state logic: arbitration FSM, packet counters and 2-entry skid buffer.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        pkt_cnt_d = pkt_cnt_q;

        case (state_q)
            IDLE: begin
                if (found_s) begin
                    sel_d   = cand_s;
                    state_d = PASS;
                end else begin
                    state_d = IDLE;
                end
            end
            PASS: begin
                if (accept_s && in_last_s) begin
                    for (int c = 0; c < NUM_CHANNELS; c++) begin
                        if (CHAN_W'(c) == sel_q) begin
                            pkt_cnt_d[c*16 +: 16] = pkt_cnt_q[c*16 +: 16] + 16'd1;
                        end else begin
                            pkt_cnt_d[c*16 +: 16] = pkt_cnt_q[c*16 +: 16];
                        end
                    end
                    if (sel_q == CHAN_W'(NUM_CHANNELS - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = sel_q + CHAN_W'(1);
                    end
                    state_d = IDLE;
                end else begin
                    state_d = PASS;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entry 0 is always the oldest beat; a pop shifts entry 1 forward.
        case ({accept_s, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = new_ent_s;
                end else begin
                    ent1_d = new_ent_s;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = new_ent_s;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = new_ent_s;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Registered output controls, computed from the next state so they line up with it.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            rdy_d[c] = (state_d == PASS) && (sel_d == CHAN_W'(c)) &&
                       (cnt_d != 2'd2) && ACTIVE_MASK[c];
        end
        vld_d  = (cnt_d != 2'd0);
        busy_d = (state_d == PASS) || (cnt_d != 2'd0);
    end

    // State and datapath registers; clear acts as a synchronous reset with top priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= 2'd0;
            ent0_q    <= '0;
            ent1_q    <= '0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdy_q     <= '0;
            pkt_cnt_q <= '0;
        end else if (clear) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= 2'd0;
            ent0_q    <= '0;
            ent1_q    <= '0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdy_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign i_tready                   = rdy_q;
    assign {o_tchan, o_tlast, o_tdata} = ent0_q;
    assign o_tvalid                   = vld_q;
    assign pkt_cnt                    = pkt_cnt_q;
    assign busy                       = busy_q;

endmodule

// File: tb/tb_predistort_gather.sv
// Self-checking bench for predistort_gather: randomized packets are queued per
// channel, an abstract round-robin model predicts the merged output order and
// packet counts, and a scoreboard checks every output beat.
module tb_predistort_gather;

    typedef logic [16:0] beat_t;              // {last, data}

    logic        clk = 1'b0;
    logic        reset_n, clear;
    logic [63:0] i_tdata;
    logic [3:0]  i_tlast, i_tvalid, i_tready;
    logic [15:0] o_tdata;
    logic [2:0]  o_tchan;
    logic        o_tlast, o_tvalid, o_tready;
    logic [63:0] pkt_cnt;
    logic        busy;

    // second instance with channel 2 masked off
    logic [63:0] m_tdata;
    logic [3:0]  m_tlast, m_tvalid, m_tready;
    logic [15:0] m_odata;
    logic [2:0]  m_ochan;
    logic        m_olast, m_ovalid, m_oready;
    logic [63:0] m_cnt;
    logic        m_busy;

    int          n_checks = 0;
    int          n_fail   = 0;

    beat_t       src_q [4][$];
    logic [19:0] exp_q[$];                    // {chan, last, data}
    logic [15:0] exp_cnt [4];
    logic [3:0]  in_pkt;
    int          m_ptr;
    int          rdy_mode;                    // 0 high, 1 toggle, 2 random, 3 low
    bit          drop_en;
    int          acc_cnt;
    int          cyc;
    bit          stall_prev;
    logic [19:0] stall_val;
    int          out_cyc[$];
    int          out_chan[$];

    always #5 clk = ~clk;

    predistort_gather dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tchan(o_tchan), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .pkt_cnt(pkt_cnt), .busy(busy)
    );

    predistort_gather #(.ACTIVE_MASK(4'b1011)) dut_m (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .i_tdata(m_tdata), .i_tlast(m_tlast), .i_tvalid(m_tvalid), .i_tready(m_tready),
        .o_tdata(m_odata), .o_tchan(m_ochan), .o_tlast(m_olast), .o_tvalid(m_ovalid),
        .o_tready(m_oready), .pkt_cnt(m_cnt), .busy(m_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int c, input int len, input logic [15:0] base);
        for (int b = 0; b < len; b++) src_q[c].push_back({(b == len - 1) ? 1'b1 : 1'b0, base + 16'(b)});
    endtask

    // Predict whole-packet round-robin order over every packet currently queued.
    task automatic plan();
        beat_t pend [4][$];
        beat_t b;
        int    c;
        bit    any;
        for (int i = 0; i < 4; i++) pend[i] = src_q[i];
        forever begin
            any = 1'b0;
            c   = 0;
            for (int k = 0; k < 4; k++) begin
                if (!any && pend[(m_ptr + k) % 4].size() > 0) begin
                    any = 1'b1;
                    c   = (m_ptr + k) % 4;
                end
            end
            if (!any) break;
            do begin
                b = pend[c].pop_front();
                exp_q.push_back({3'(c), b});
            end while (!b[16]);
            exp_cnt[c] = exp_cnt[c] + 16'd1;
            m_ptr = (c + 1) % 4;
        end
    endtask

    task automatic drive_inputs();
        for (int c = 0; c < 4; c++) begin
            if (src_q[c].size() > 0) begin
                i_tdata[c*16 +: 16] = src_q[c][0][15:0];
                i_tlast[c]          = src_q[c][0][16];
                i_tvalid[c]         = !in_pkt[c] || !drop_en || ($urandom_range(0, 3) != 0);
            end else begin
                i_tdata[c*16 +: 16] = 16'h0;
                i_tlast[c]          = 1'b0;
                i_tvalid[c]         = 1'b0;
            end
        end
        case (rdy_mode)
            0:       o_tready = 1'b1;
            1:       o_tready = ~o_tready;
            2:       o_tready = 1'($urandom_range(0, 1));
            default: o_tready = 1'b0;
        endcase
    endtask

    // One clock: sample at negedge, update sources and drive just after posedge.
    task automatic cycle();
        logic [3:0]  hs_in;
        logic [19:0] e;
        beat_t       b;
        @(negedge clk);
        hs_in   = i_tvalid & i_tready;
        acc_cnt += $countones(hs_in);
        check("ready_onehot", 64'($countones(i_tready) <= 1), 64'd1);
        if (stall_prev) check("hold_stable", {o_tvalid, o_tchan, o_tlast, o_tdata}, {1'b1, stall_val});
        if (o_tvalid) check("busy_with_data", busy, 1'b1);
        if (o_tvalid && o_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {o_tchan, o_tlast, o_tdata}, 20'hFFFFF);
            end else begin
                e = exp_q.pop_front();
                check("out_beat", {o_tchan, o_tlast, o_tdata}, e);
            end
            out_cyc.push_back(cyc);
            out_chan.push_back(int'(o_tchan));
        end
        stall_prev = o_tvalid && !o_tready;
        stall_val  = {o_tchan, o_tlast, o_tdata};
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < 4; c++) begin
            if (hs_in[c] && src_q[c].size() > 0) begin
                b         = src_q[c].pop_front();
                in_pkt[c] = !b[16];
            end
        end
        drive_inputs();
    endtask

    task automatic drain();
        int n = 0;
        int left;
        forever begin
            left = exp_q.size();
            for (int c = 0; c < 4; c++) left += src_q[c].size();
            if ((left == 0 && !busy) || n >= 3000) break;
            cycle();
            n++;
        end
        check("drained", 64'(left), 64'd0);
    endtask

    task automatic check_counts(input string tag);
        for (int c = 0; c < 4; c++) check(tag, pkt_cnt[c*16 +: 16], exp_cnt[c]);
    endtask

    task automatic flush_model();
        for (int c = 0; c < 4; c++) begin
            src_q[c].delete();
            exp_cnt[c] = 16'd0;
        end
        exp_q.delete();
        in_pkt     = 4'b0;
        m_ptr      = 0;
        stall_prev = 1'b0;
        drive_inputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pv;
        int          got[$];
        int          ord[4];
        int          n;
        reset_n = 1'b0; clear = 1'b0; o_tready = 1'b0; rdy_mode = 0; drop_en = 1'b0;
        i_tdata = '0; i_tlast = '0; i_tvalid = '0;
        m_tdata = '0; m_tlast = '0; m_tvalid = '0; m_oready = 1'b0;
        acc_cnt = 0; cyc = 0;
        flush_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_o_tvalid", o_tvalid, 1'b0);
        check("rst_o_tdata", o_tdata, 16'h0);
        check("rst_o_tchan", o_tchan, 3'd0);
        check("rst_o_tlast", o_tlast, 1'b0);
        check("rst_i_tready", i_tready, 4'h0);
        check("rst_pkt_cnt", pkt_cnt, 64'h0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // all channels valid, 3-beat packets, full-rate sink
        for (int c = 0; c < 4; c++) add_pkt(c, 3, 16'hC000 | 16'(c << 4));
        add_pkt(0, 3, 16'hC080);
        plan();
        out_cyc.delete(); out_chan.delete();
        rdy_mode = 0;
        drive_inputs();
        drain();
        check("t1_beats", 64'(out_chan.size()), 64'd15);
        for (int i = 1; i < out_chan.size(); i++)
            check("t1_gap", 64'(out_cyc[i] - out_cyc[i-1]), (out_chan[i] != out_chan[i-1]) ? 64'd2 : 64'd1);
        check_counts("t1_pkt_cnt");

        // single channel, toggling sink ready
        add_pkt(2, 5, 16'h2A00);
        plan();
        rdy_mode = 1;
        drain();

        // sink stalled: only the two buffer slots fill
        add_pkt(0, 6, 16'h3300);
        plan();
        rdy_mode = 3;
        drive_inputs();
        acc_cnt = 0;
        repeat (12) cycle();
        check("t3_accepted", 64'(acc_cnt), 64'd2);
        check("t3_i_tready", i_tready, 4'h0);
        rdy_mode = 0;
        drain();
        check_counts("t3_pkt_cnt");

        // randomized traffic with mid-packet valid gaps and random sink ready
        drop_en  = 1'b1;
        rdy_mode = 2;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 4; c++) begin
                n = $urandom_range(0, 3);
                for (int p = 0; p < n; p++) add_pkt(c, $urandom_range(1, 6), 16'($urandom));
            end
            plan();
            drive_inputs();
            drain();
            check_counts("rand_pkt_cnt");
        end
        drop_en = 1'b0;

        // masked instance: channel 2 never granted
        m_tvalid = 4'hF; m_tlast = 4'hF; m_oready = 1'b1;
        m_tdata  = {16'd3, 16'd2, 16'd1, 16'd0};
        repeat (12) begin
            @(negedge clk);
            check("mask_ready2", m_tready[2], 1'b0);
            if (m_ovalid) begin
                got.push_back(int'(m_ochan));
                check("mask_data", m_odata, 16'(m_ochan));
            end
            @(posedge clk); #1;
        end
        m_tvalid = 4'h0;
        ord = '{0, 1, 3, 0};
        for (int i = 0; i < 4; i++) check("mask_order", (i < got.size()) ? 64'(got[i]) : 64'd7, 64'(ord[i]));

        // reset in the middle of a packet, then a clean ch1 packet
        rdy_mode = 0;
        add_pkt(0, 4, 16'h5500);
        plan();
        drive_inputs();
        acc_cnt = 0;
        n = 0;
        while (acc_cnt < 2 && n < 20) begin cycle(); n++; end
        check("t5_pre_accept", 64'(acc_cnt), 64'd2);
        reset_n = 1'b0;
        #2;
        check("t5_rst_o_tvalid", o_tvalid, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_i_tready", i_tready, 4'h0);
        check("t5_rst_o_tdata", {o_tchan, o_tlast, o_tdata}, 20'h0);
        flush_model();
        @(posedge clk); #1;
        reset_n = 1'b1;
        add_pkt(1, 3, 16'h1100);
        plan();
        drive_inputs();
        drain();
        check_counts("t5_pkt_cnt");

        // counter wrap: preload ch0 to FFFF, then one more packet
        pv = '0;
        for (int c = 1; c < 4; c++) pv[c*16 +: 16] = exp_cnt[c];
        pv[15:0] = 16'hFFFF;
        exp_cnt[0] = 16'hFFFF;
        force dut.pkt_cnt_q = pv;
        #1;
        release dut.pkt_cnt_q;
        add_pkt(0, 1, 16'h0F0F);
        plan();
        drive_inputs();
        drain();
        check("t6_wrap", pkt_cnt[15:0], 16'h0000);
        check_counts("t6_pkt_cnt");

        // soft clear mid-packet
        add_pkt(0, 4, 16'h6600);
        plan();
        drive_inputs();
        acc_cnt = 0;
        n = 0;
        while (acc_cnt < 2 && n < 20) begin cycle(); n++; end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("t6_clr_o_tvalid", o_tvalid, 1'b0);
        check("t6_clr_busy", busy, 1'b0);
        check("t6_clr_pkt_cnt", pkt_cnt, 64'h0);
        flush_model();
        add_pkt(3, 2, 16'h7700);
        plan();
        drive_inputs();
        drain();
        check_counts("t6_post_clear_cnt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
